// File: rtl/uart_cmd_ctl.sv
// Command-frame parser between the UART FIFO user ports and a simple register bus.
// Frames: SYNC,0x01,ADDR,DATA -> ACK ; SYNC,0x02,ADDR -> register byte.
module uart_cmd_ctl #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter logic [7:0]  ACK_BYTE    = 8'h06,
    parameter logic [7:0]  NAK_BYTE    = 8'h15,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_buf_not_empty,
    input  logic [7:0] rx_get_data,
    output logic       rx_read,
    input  logic       tx_buf_not_full,
    output logic       tx_write,
    output logic [7:0] tx_send_data,
    output logic       reg_we,
    output logic       reg_re,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       err_nak,
    output logic       err_timeout
);

    localparam int unsigned    CntW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYC);
    localparam logic [7:0]     CmdWrite = 8'h01;
    localparam logic [7:0]     CmdRead  = 8'h02;

    typedef enum logic [2:0] {StIdle, StPop, StCap, StExec, StRdcap, StTxw} state_e;

    state_e          state_q, state_d;
    logic [1:0]      fld_q, fld_d;
    logic            is_read_q, is_read_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      resp_q, resp_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic cmd_ok;
    logic timeout_hit;
    logic nak_hit;

    assign cmd_ok      = (rx_get_data == CmdWrite) || (rx_get_data == CmdRead);
    // Idle gap inside a partial frame has reached the limit.
    assign timeout_hit = (state_q == StIdle) && !rx_buf_not_empty && (fld_q != 2'd0) &&
                         (cnt_q == CntMax);
    assign nak_hit     = (state_q == StCap) && (fld_q == 2'd1) && !cmd_ok;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            fld_q     <= 2'd0;
            is_read_q <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            resp_q    <= 8'h00;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            fld_q     <= fld_d;
            is_read_q <= is_read_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            resp_q    <= resp_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        fld_d     = fld_q;
        is_read_d = is_read_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        resp_d    = resp_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (rx_buf_not_empty) begin
                    state_d = StPop;
                end else if (timeout_hit) begin
                    fld_d = 2'd0;
                    cnt_d = '0;
                end else if (fld_q != 2'd0) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StPop: begin
                cnt_d   = '0;
                state_d = StCap;
            end
            StCap: begin
                state_d = StIdle;
                case (fld_q)
                    2'd0: begin
                        if (rx_get_data == SYNC_BYTE) fld_d = 2'd1;
                    end
                    2'd1: begin
                        if (cmd_ok) begin
                            is_read_d = (rx_get_data == CmdRead);
                            fld_d     = 2'd2;
                        end else begin
                            resp_d  = NAK_BYTE;
                            state_d = StTxw;
                        end
                    end
                    2'd2: begin
                        addr_d = rx_get_data;
                        if (is_read_q) state_d = StExec;
                        else           fld_d   = 2'd3;
                    end
                    default: begin
                        wdata_d = rx_get_data;
                        state_d = StExec;
                    end
                endcase
            end
            StExec: begin
                if (is_read_q) begin
                    state_d = StRdcap;
                end else begin
                    resp_d  = ACK_BYTE;
                    state_d = StTxw;
                end
            end
            StRdcap: begin
                resp_d  = reg_rdata;
                state_d = StTxw;
            end
            StTxw: begin
                if (tx_buf_not_full) begin
                    fld_d   = 2'd0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rx_read      = (state_q == StPop);
        reg_we       = (state_q == StExec) && !is_read_q;
        reg_re       = (state_q == StExec) && is_read_q;
        tx_write     = (state_q == StTxw) && tx_buf_not_full;
        tx_send_data = resp_q;
        reg_addr     = addr_q;
        reg_wdata    = wdata_q;
        busy         = (fld_q != 2'd0) || (state_q != StIdle);
        err_nak      = nak_hit;
        err_timeout  = timeout_hit;
    end

endmodule

// File: tb/tb_uart_cmd_ctl.sv
// Scoreboard bench for uart_cmd_ctl: FIFO and register-bank models, directed frames,
// expected bus events queued by stimulus and checked by an independent monitor.
module tb_uart_cmd_ctl;

    localparam int unsigned TO = 20;
    localparam int EvWe = 0, EvRe = 1, EvTx = 2, EvNak = 3, EvTmo = 4;
    // 6 cycles to consume A5 01, then TO+1 idle cycles until the pulse is sampled.
    localparam int TmoTicks = 6 + TO + 1;

    typedef struct {
        int         kind;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_buf_not_empty;
    logic [7:0] rx_get_data;
    logic       rx_read;
    logic       tx_buf_not_full;
    logic       tx_write;
    logic [7:0] tx_send_data;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       err_nak;
    logic       err_timeout;

    ev_t        exp_q[$];
    logic [7:0] fifo[$];
    logic [7:0] regs[256];
    int         checks = 0;
    int         failures = 0;
    int         tx_cnt = 0;
    int         rd_cnt = 0;

    always #5 clk = ~clk;

    uart_cmd_ctl #(
        .SYNC_BYTE  (8'hA5),
        .ACK_BYTE   (8'h06),
        .NAK_BYTE   (8'h15),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_buf_not_empty(rx_buf_not_empty),
        .rx_get_data     (rx_get_data),
        .rx_read         (rx_read),
        .tx_buf_not_full (tx_buf_not_full),
        .tx_write        (tx_write),
        .tx_send_data    (tx_send_data),
        .reg_we          (reg_we),
        .reg_re          (reg_re),
        .reg_addr        (reg_addr),
        .reg_wdata       (reg_wdata),
        .reg_rdata       (reg_rdata),
        .busy            (busy),
        .err_nak         (err_nak),
        .err_timeout     (err_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] addr, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        rx_buf_not_empty = 1'b1;
    endtask

    // One clock: sample strobes at negedge, update FIFO/register models just after posedge.
    task automatic tick();
        logic       pn, rn, wn;
        logic [7:0] wa, wd;
        @(negedge clk);
        pn = rx_read;
        rn = reg_re;
        wn = reg_we;
        wa = reg_addr;
        wd = reg_wdata;
        if (tx_write) tx_cnt++;
        if (rx_read) rd_cnt++;
        @(posedge clk);
        #1;
        if (pn && fifo.size() != 0) rx_get_data = fifo.pop_front();
        rx_buf_not_empty = (fifo.size() != 0);
        if (wn) regs[wa] = wd;
        if (rn) reg_rdata = regs[wa];
    endtask

    task automatic drain(input string name, input int budget, input bit need_idle);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || (need_idle && busy)) && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || (need_idle && busy)) begin
            checks++;
            failures++;
            $display("FAIL %s: timed out, %0d events outstanding, busy=%0b",
                     name, exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    task automatic got(input int kind, input logic [7:0] addr, input logic [7:0] data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind=%0d addr=%0h data=%0h, none expected",
                     kind, addr, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.addr != addr || e.data != data) begin
                failures++;
                $display("FAIL event: got kind=%0d addr=%0h data=%0h expected kind=%0d addr=%0h data=%0h",
                         kind, addr, data, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Monitor: decoupled from stimulus, pops the scoreboard on every DUT strobe.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (rx_read || tx_write || reg_we || reg_re) begin
                checks++;
                if (int'(rx_read) + int'(tx_write) + int'(reg_we) + int'(reg_re) > 1) begin
                    failures++;
                    $display("FAIL strobe_exclusive: rd=%0b tx=%0b we=%0b re=%0b expected one",
                             rx_read, tx_write, reg_we, reg_re);
                end
            end
            if (reg_we)      got(EvWe, reg_addr, reg_wdata);
            if (reg_re)      got(EvRe, reg_addr, 8'h00);
            if (err_nak)     got(EvNak, 8'h00, 8'h00);
            if (err_timeout) got(EvTmo, 8'h00, 8'h00);
            if (tx_write)    got(EvTx, 8'h00, tx_send_data);
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rx_read"}, 32'(rx_read), 0);
        chk({tag, "_tx_write"}, 32'(tx_write), 0);
        chk({tag, "_reg_we"}, 32'(reg_we), 0);
        chk({tag, "_reg_re"}, 32'(reg_re), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_errs"}, {30'd0, err_nak, err_timeout}, 0);
        chk({tag, "_data"}, {8'd0, tx_send_data, reg_addr, reg_wdata}, 0);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        rx_buf_not_empty = 1'b0;
        rx_get_data = 8'h00;
        tx_buf_not_full = 1'b1;
        reg_rdata = 8'h00;
        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
        regs[8'h00] = 8'h4E;
        regs[8'h05] = 8'h77;
        regs[8'h07] = 8'hC3;

        repeat (3) tick();
        chk_outputs_zero("reset");
        rst = 1'b1;
        tick();

        // Write frame
        expect_ev(EvWe, 8'h03, 8'h5A);
        expect_ev(EvTx, 8'h00, 8'h06);
        push(8'hA5); push(8'h01); push(8'h03); push(8'h5A);
        drain("write", 200, 1'b1);
        chk("write_addr_held", 32'(reg_addr), 32'h03);
        chk("write_reg_model", 32'(regs[8'h03]), 32'h5A);

        // Read frame
        expect_ev(EvRe, 8'h07, 8'h00);
        expect_ev(EvTx, 8'h00, 8'hC3);
        push(8'hA5); push(8'h02); push(8'h07);
        drain("read", 200, 1'b1);

        // Sync hunt
        expect_ev(EvWe, 8'h01, 8'h11);
        expect_ev(EvTx, 8'h00, 8'h06);
        push(8'h00); push(8'hFF); push(8'hA5); push(8'h01); push(8'h01); push(8'h11);
        drain("sync_hunt", 300, 1'b1);

        // Bad command then read of address 0
        expect_ev(EvNak, 8'h00, 8'h00);
        expect_ev(EvTx, 8'h00, 8'h15);
        expect_ev(EvRe, 8'h00, 8'h00);
        expect_ev(EvTx, 8'h00, 8'h4E);
        push(8'hA5); push(8'h09); push(8'hA5); push(8'h02); push(8'h00);
        drain("bad_cmd", 300, 1'b1);

        // Timeout on partial frame
        expect_ev(EvTmo, 8'h00, 8'h00);
        push(8'hA5); push(8'h01);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
            if (n == 10) chk("timeout_busy_mid", 32'(busy), 1);
        end
        chk("timeout_latency", 32'(n), 32'(TmoTicks));
        exp_q.delete();
        chk("timeout_busy_after", 32'(busy), 0);
        expect_ev(EvWe, 8'h02, 8'h33);
        expect_ev(EvTx, 8'h00, 8'h06);
        push(8'hA5); push(8'h01); push(8'h02); push(8'h33);
        drain("after_timeout", 200, 1'b1);

        // Backpressure: response held, trailing bytes left in the FIFO
        tx_buf_not_full = 1'b0;
        tx_cnt = 0;
        rd_cnt = 0;
        expect_ev(EvRe, 8'h07, 8'h00);
        expect_ev(EvTx, 8'h00, 8'hC3);
        push(8'hA5); push(8'h02); push(8'h07); push(8'hA5); push(8'h02);
        repeat (30) tick();
        chk("stall_no_tx", 32'(tx_cnt), 0);
        chk("stall_pops", 32'(rd_cnt), 3);
        chk("stall_fifo_left", 32'(fifo.size()), 2);
        chk("stall_busy", 32'(busy), 1);
        tx_buf_not_full = 1'b1;
        drain("stall_release", 50, 1'b0);
        repeat (8) tick();
        chk("partial_busy", 32'(busy), 1);

        // Reset mid-frame, then a fresh read frame
        rst = 1'b0;
        tick();
        chk_outputs_zero("midreset");
        rst = 1'b1;
        expect_ev(EvRe, 8'h05, 8'h00);
        expect_ev(EvTx, 8'h00, 8'h77);
        push(8'hA5); push(8'h02); push(8'h05);
        drain("post_reset", 200, 1'b1);

        repeat (5) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
